// File: rtl/ucode_loader.sv
// Micro-instruction loader: parses a counted, XOR-checksummed byte stream into
// WORD_W-bit words and writes them sequentially from a latched base address.
module ucode_loader #(
    parameter int ADDR_W = 6,
    parameter int WORD_W = 17,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [2:0] {IDLE, COUNT, B0, B1, B2, WRITE, CSUM} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;
    logic [ADDR_W:0]     ww_q, ww_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          b0_q, b0_d;
    logic [7:0]          b1_q, b1_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                xfer;
    logic [ADDR_W:0]     ww_inc;
    logic [ADDR_W+8:0]   end_addr;

    assign in_ready = (state_q == COUNT) || (state_q == B0) || (state_q == B1) ||
                      (state_q == B2) || (state_q == CSUM);
    assign xfer     = in_valid && in_ready;
    assign ww_inc   = ww_q + 1'b1;
    // Wide sum so the range check itself can never overflow.
    assign end_addr = (ADDR_W+9)'(base_q) + (ADDR_W+9)'(in_data);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ww_d      = ww_q;
        n_d       = n_q;
        csum_d    = csum_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    csum_d  = '0;
                    ww_d    = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (xfer) begin
                    csum_d = csum_q ^ in_data;
                    if (in_data == 8'd0 || end_addr > (ADDR_W+9)'(DEPTH)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        n_d     = (ADDR_W+1)'(in_data);
                        state_d = B0;
                    end
                end
            end
            B0: begin
                if (xfer) begin
                    b0_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = B1;
                end
            end
            B1: begin
                if (xfer) begin
                    b1_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = B2;
                end
            end
            B2: begin
                if (xfer) begin
                    if (in_data[7:1] != 7'd0) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        csum_d    = csum_q ^ in_data;
                        wr_data_d = WORD_W'({in_data[0], b1_q, b0_q});
                        wr_addr_d = base_q + ww_q[ADDR_W-1:0];
                        state_d   = WRITE;
                    end
                end
            end
            WRITE: begin
                ww_d    = ww_inc;
                state_d = (ww_inc == n_q) ? CSUM : B0;
            end
            CSUM: begin
                if (xfer) begin
                    if (in_data == csum_q) done_d = 1'b1;
                    else                   err_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ww_q      <= '0;
            n_q       <= '0;
            csum_q    <= '0;
            b0_q      <= '0;
            b1_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ww_q      <= ww_d;
            n_q       <= n_d;
            csum_q    <= csum_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wr_en         = (state_q == WRITE);
    assign busy          = (state_q != IDLE);
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign words_written = ww_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_ucode_loader.sv
// Scoreboard bench for ucode_loader: expected writes and done/err outcomes are
// queued by the stimulus and consumed by an independent output monitor.
module tb_ucode_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  base_addr = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [16:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  words_written;

    ucode_loader #(.ADDR_W(6), .WORD_W(17), .DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .done(done), .err(err), .words_written(words_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_write;
        logic [5:0]  addr;
        logic [16:0] data;
        bit          is_done;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] seq [0:7];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic void exp_wr(input logic [5:0] a, input logic [16:0] d);
        exp_t e;
        e.is_write = 1'b1; e.addr = a; e.data = d; e.is_done = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_end(input bit is_done);
        exp_t e;
        e.is_write = 1'b0; e.addr = '0; e.data = '0; e.is_done = is_done;
        exp_q.push_back(e);
    endfunction

    // Monitor: consumes expectations whenever the DUT presents a write or an outcome pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done && err) begin
                checks++; failures++;
                $display("FAIL done_err_overlap: got done=1 err=1 expected at most one");
            end
            if (wr_en) begin
                checks++;
                if (exp_q.size() == 0 || !exp_q[0].is_write) begin
                    failures++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", wr_addr, wr_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (wr_addr !== e.addr || wr_data !== e.data) begin
                        failures++;
                        $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                                 wr_addr, wr_data, e.addr, e.data);
                    end
                end
            end
            if (done || err) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].is_write) begin
                    failures++;
                    $display("FAIL unexpected_outcome: got done=%0b err=%0b expected none", done, err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (done !== e.is_done || err !== !e.is_done) begin
                        failures++;
                        $display("FAIL outcome: got done=%0b err=%0b expected done=%0b",
                                 done, err, e.is_done);
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [5:0] b);
        start = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data = b;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 50) begin
                checks++; failures++;
                $display("FAIL ready_timeout: got in_ready=0 for 50 cycles expected 1");
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_seq(input logic [5:0] b, input int n, input int maxgap);
        do_start(b);
        for (int i = 0; i < n; i++)
            send_byte(seq[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_wr_en"},    32'(wr_en),    32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_err"},      32'(err),      32'd0);
        chk({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
        chk({tag, "_wr_data"},  32'(wr_data),  32'd0);
        chk({tag, "_words"},    32'(words_written), 32'd0);
    endtask

    initial begin
        #3;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word at address 0: word 0x11234, checksum 0x26.
        seq = '{8'h01, 8'h34, 8'h12, 8'h01, 8'h26, 8'h00, 8'h00, 8'h00};
        exp_wr(6'd0, 17'h11234); exp_end(1'b1);
        run_seq(6'd0, 5, 0);
        @(negedge clk);
        chk("basic_words", 32'(words_written), 32'd1);
        chk("basic_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Range overflow: 62 + 3 > 64.
        seq = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_end(1'b0);
        run_seq(6'd62, 1, 0);
        @(negedge clk);
        chk("range_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Zero count is rejected.
        seq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_end(1'b0);
        run_seq(6'd0, 1, 0);
        repeat (2) begin @(posedge clk); #1; end

        // Top boundary: 63 + 1 == 64 is legal. Checksum 01^AB^CD^01 = 66.
        seq = '{8'h01, 8'hAB, 8'hCD, 8'h01, 8'h66, 8'h00, 8'h00, 8'h00};
        exp_wr(6'd63, 17'h1CDAB); exp_end(1'b1);
        run_seq(6'd63, 5, 0);
        repeat (2) begin @(posedge clk); #1; end

        // Reserved bits set in the second word's b2.
        seq = '{8'h02, 8'h11, 8'h22, 8'h00, 8'h33, 8'h44, 8'h03, 8'h00};
        exp_wr(6'd5, 17'h02211); exp_end(1'b0);
        run_seq(6'd5, 7, 0);
        @(negedge clk);
        chk("resv_words", 32'(words_written), 32'd1);
        @(posedge clk); #1;

        // Stalled stream with a bad checksum (correct value would be 0x03).
        seq = '{8'h02, 8'h55, 8'hAA, 8'h01, 8'h0F, 8'hF0, 8'h00, 8'h04};
        exp_wr(6'd10, 17'h1AA55); exp_wr(6'd11, 17'h0F00F); exp_end(1'b0);
        run_seq(6'd10, 8, 3);
        @(negedge clk);
        chk("stall_words", 32'(words_written), 32'd2);
        @(posedge clk); #1;

        // Reset while the first word's b1 is pending.
        seq = '{8'h01, 8'h34, 8'h12, 8'h01, 8'h26, 8'h00, 8'h00, 8'h00};
        run_seq(6'd0, 2, 0);
        chk("preabort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_wr(6'd0, 17'h11234); exp_end(1'b1);
        run_seq(6'd0, 5, 0);
        @(negedge clk);
        chk("post_reset_words", 32'(words_written), 32'd1);

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ucode_loader.md
UCODE_LOADER -- requirements
Module: ucode_loader

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 6, micro-instruction memory address width; WORD_W, default 17, micro-instruction width; DEPTH, default 64, memory entries.
REQ-002 Ports SHALL be:
  clk  input  1  single clock, rising edge
  rst_n  input  1  asynchronous active-low reset
  start  input  1  one-cycle request to begin a load
  base_addr  input  ADDR_W  first memory address to write, sampled when start is accepted
  in_valid  input  1  byte-stream valid
  in_data  input  8  byte-stream data
  in_ready  output  1  byte-stream ready
  wr_en  output  1  micro-instruction memory write strobe
  wr_addr  output  ADDR_W  write address
  wr_data  output  WORD_W  write data
  busy  output  1  load in progress
  done  output  1  one-cycle pulse: load completed, checksum good
  err  output  1  one-cycle pulse: load aborted
  words_written  output  ADDR_W+1  words written by the current or last load
REQ-003 The design SHALL use only clk, with rst_n asynchronous and active-low.

Function
REQ-004 A byte SHALL transfer on a rising clk edge where in_valid and in_ready are both 1.
REQ-005 Stream format SHALL be: count byte N, then N groups of 3 bytes (b0, b1, b2), then one checksum byte.
REQ-006 Each word SHALL be {b2[0], b1, b0}; b2[7:1] are reserved and SHALL be 0.
REQ-007 Checksum SHALL be the XOR of the count byte and all data bytes.
REQ-008 States SHALL be IDLE, COUNT, B0, B1, B2, WRITE, CSUM.
REQ-009 IDLE: in_ready=0, busy=0; start=1 SHALL latch base_addr, clear the checksum and words_written, and go to COUNT.
REQ-010 start SHALL be ignored when busy=1.
REQ-011 COUNT: on transfer, if N==0 or base_addr+N>DEPTH, pulse err and go to IDLE with no write; otherwise latch N and go to B0.
REQ-012 B0 SHALL go to B1, and B1 SHALL go to B2, each on transfer.
REQ-013 B2: on transfer, if reserved bits are non-zero, pulse err and go to IDLE with no write; otherwise go to WRITE.
REQ-014 WRITE SHALL last exactly one cycle with in_ready=0 and wr_en=1, wr_addr=base_addr+words_written, and wr_data equal to the assembled word.
REQ-015 words_written SHALL increment in the WRITE cycle; next state SHALL be CSUM if words_written+1==N, else B0.
REQ-016 CSUM: on transfer, pulse done if the byte equals the running XOR, else pulse err; then go to IDLE.
REQ-017 Words already written SHALL NOT be rolled back on err.
REQ-018 in_ready SHALL be 1 exactly in COUNT, B0, B1, B2 and CSUM.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 done and err SHALL never assert in the same cycle, and each SHALL be high for exactly one cycle, registered.
REQ-021 Stalls SHALL be supported: in_valid low for any number of cycles holds the state and partial word unchanged.
REQ-022 wr_addr arithmetic SHALL never wrap, guaranteed by the REQ-011 range check; a load with base_addr+N==DEPTH is legal.
REQ-023 wr_en SHALL be 0 in all states other than WRITE.

Reset
REQ-024 rst_n low SHALL asynchronously force state to IDLE, and force in_ready, wr_en, busy, done and err to 0.
REQ-025 rst_n low SHALL asynchronously force wr_addr, wr_data, words_written, the checksum and all partial-word registers to 0.
REQ-026 Reset asserted mid-load SHALL abort with no further writes and no done/err pulse.
REQ-027 After rst_n deasserts, the next load SHALL start cleanly on the next start.

Verification
REQ-028 base_addr=0; stream 0x01,0x34,0x12,0x01,0x26 -> one wr_en with wr_addr=0 and wr_data=0x11234; done pulse; words_written=1.
REQ-029 base_addr=62; count 0x03 -> err pulse on the count transfer, no wr_en, busy=0 next cycle.
REQ-030 base_addr=63; N=1 with valid data and checksum -> write to address 63, done pulse (top-boundary legal case).
REQ-031 base_addr=5; N=2, second word b2=0x03 -> first word written at address 5, err on the second b2, no second write, words_written=1.
REQ-032 Valid N=2 stream with in_valid toggled randomly and a bad checksum byte -> writes at base_addr and base_addr+1 with correct data, err pulse, no done.
REQ-033 rst_n pulsed low during B1 of the first word -> no wr_en and all outputs 0; a subsequent start with the REQ-028 stream -> done.
